// File: rtl/booth_pkg.sv
// Shared types and helpers for the round-robin Booth multiplier arbiter.
// Build option: BOOTH_ARB_APPROX_EN zeroes the low product bits.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Radix-4 Booth digit patterns {b[2i+1], b[2i], b[2i-1]}
    localparam logic [2:0] BD_ZERO   = 3'b000;
    localparam logic [2:0] BD_P1_LO  = 3'b001;
    localparam logic [2:0] BD_P1_HI  = 3'b010;
    localparam logic [2:0] BD_P2     = 3'b011;
    localparam logic [2:0] BD_M2     = 3'b100;
    localparam logic [2:0] BD_M1_LO  = 3'b101;
    localparam logic [2:0] BD_M1_HI  = 3'b110;
    localparam logic [2:0] BD_ZERO_N = 3'b111;

    // Digits needed; one extra covers unsigned B with its MSB set.
    function automatic int booth_cnt(input int width_b);
        return (width_b + 2) / 2;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/booth_radix4_core.sv
// Sequential radix-4 Booth multiplier: one digit per clock.
// Holds the shifted multiplicand, multiplier, accumulator and step count.
module booth_radix4_core
    import booth_pkg::*;
#(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MUL = WIDTH_A + WIDTH_B,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH_A-1:0]   a_i,
    input  logic [WIDTH_B-1:0]   b_i,
    output logic                 done_o,
    output logic [WIDTH_MUL-1:0] product_o
);

    localparam int CNT = booth_cnt(WIDTH_B);
    localparam int AW  = WIDTH_MUL + 2;
    localparam int BXW = 2 * CNT;
    localparam int CW  = $clog2(CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(CNT - 1);

    logic [AW-1:0]  a_q, a_d;
    logic [BXW:0]   b_q, b_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  step_q, step_d;
    logic           run_q, run_d;
    logic           done_q, done_d;

    logic [AW-1:0]  a_ext;
    logic [BXW:0]   b_ext;
    logic           a_sx, b_sx;
    logic [AW-1:0]  pp;

    assign a_sx  = SIGNED & a_i[WIDTH_A-1];
    assign b_sx  = SIGNED & b_i[WIDTH_B-1];
    assign a_ext = {{(AW-WIDTH_A){a_sx}}, a_i};
    assign b_ext = {{(BXW-WIDTH_B){b_sx}}, b_i, 1'b0};

    // Partial product selected by the current Booth digit
    always_comb begin
        pp = '0;
        unique case (b_q[2:0])
            BD_ZERO, BD_ZERO_N: pp = '0;
            BD_P1_LO, BD_P1_HI: pp = a_q;
            BD_P2:              pp = a_q << 1;
            BD_M2:              pp = -(a_q << 1);
            BD_M1_LO, BD_M1_HI: pp = -a_q;
        endcase
    end

    // Load on start, then accumulate and shift one digit per cycle
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        step_d = step_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            a_d    = a_ext;
            b_d    = b_ext;
            acc_d  = '0;
            step_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            acc_d = acc_q + pp;
            a_d   = a_q << 2;
            b_d   = b_q >> 2;
            if (step_q == LAST) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            step_q <= step_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q[WIDTH_MUL-1:0];

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one radix-4 Booth multiplier core.
// Build option: BOOTH_ARB_APPROX_EN zeroes rsp_data[APPROX_W-1:0].
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MUL = WIDTH_A + WIDTH_B,
    parameter bit SIGNED    = 1'b0,
    parameter int APPROX_W  = 16,
    parameter int ID_W      = id_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [WIDTH_MUL-1:0]         rsp_data,
    output logic                         busy
);

`ifdef BOOTH_ARB_APPROX_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif
    localparam int ZW = APPROX_EN ? APPROX_W : 0;
    localparam logic [WIDTH_MUL-1:0] KEEP = {WIDTH_MUL{1'b1}} << ZW;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH_MUL-1:0]  rsp_data_q, rsp_data_d;

    logic                  gnt_found;
    logic [ID_W-1:0]       gnt_idx;
    logic                  start;
    logic                  core_done;
    logic [WIDTH_MUL-1:0]  core_prod;

    // Circular search for the first valid requester after rr_ptr
    always_comb begin
        logic [ID_W:0] sum;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[sum[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = sum[ID_W-1:0];
            end
        end
    end

    // FSM next state, grant and response capture
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        start      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    start    = 1'b1;
                    rr_ptr_d = gnt_idx;
                    id_d     = gnt_idx;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    rsp_data_d = core_prod & KEEP;
                    rsp_id_d   = id_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    booth_radix4_core #(
        .WIDTH_A   (WIDTH_A),
        .WIDTH_B   (WIDTH_B),
        .WIDTH_MUL (WIDTH_MUL),
        .SIGNED    (SIGNED)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .a_i       (req_a[gnt_idx*WIDTH_A +: WIDTH_A]),
        .b_i       (req_b[gnt_idx*WIDTH_B +: WIDTH_B]),
        .done_o    (core_done),
        .product_o (core_prod)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule
